// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port to one-port
// memory arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   grant_t      : which port owns the current RAM access
//   CONF_CNT_MAX : saturation value of the contention counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } arb_state_t;

  typedef enum logic {
    G_INST,
    G_DATA
  } grant_t;

  localparam logic [31:0] CONF_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction-fetch port and the data port share one
// synchronous-read RAM. Accesses are serialised with a req/rdy handshake;
// data wins in S_IDLE, and S_DONE hands the RAM to the other port, so under
// contention the two ports alternate.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | no access in flight; grant data first, else instruction
//   S_ACCESS | mem_en high for the latched request
//   S_DONE   | mem_rdata valid; pulse winner's rdy, maybe grant the other port
//
// Ports:
//   clk, rstn                          clock, async active-low reset
//   i_req/i_addr -> i_rdy/i_rdata      instruction read port
//   d_req/d_we/d_addr/d_wdata
//                -> d_rdy/d_rdata      data read/write port
//   mem_en/mem_we/mem_addr/mem_wdata   RAM request (registered)
//   mem_rdata                          RAM read data, valid cycle after mem_en
//   conf_cnt                           cycles the instruction port lost arbitration
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       conf_cnt
);

  arb_state_t        r_state;
  grant_t            r_grant;
  logic              r_we;
  logic [DATA_W-1:0] r_i_hold;
  logic [DATA_W-1:0] r_d_hold;

  logic              w_i_cand;
  logic              w_d_cand;
  logic              w_take;
  logic              w_conf;
  grant_t            w_pick;
  logic [MEM_AW-1:0] w_addr_sel;

  // Byte-offset and out-of-range address bits are dropped on purpose.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{i_addr[31:MEM_AW+2], i_addr[1:0],
                                d_addr[31:MEM_AW+2], d_addr[1:0]};

  // The port served in S_DONE still holds its req this cycle, so it is
  // excluded; that is what makes contended service alternate.
  always_comb begin
    w_i_cand   = i_req && !((r_state == S_DONE) && (r_grant == G_INST));
    w_d_cand   = d_req && !((r_state == S_DONE) && (r_grant == G_DATA));
    w_take     = (r_state != S_ACCESS) && (w_i_cand || w_d_cand);
    w_pick     = w_d_cand ? G_DATA : G_INST;
    w_conf     = (r_state != S_ACCESS) && w_i_cand && w_d_cand;
    w_addr_sel = w_d_cand ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
  end

  // Read data is forwarded straight from the RAM in the rdy cycle and then
  // comes from the hold register, so the core sees it one cycle earlier.
  assign i_rdata = i_rdy ? mem_rdata : r_i_hold;
  assign d_rdata = (d_rdy && !r_we) ? mem_rdata : r_d_hold;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_grant   <= G_INST;
      r_we      <= 1'b0;
      r_i_hold  <= '0;
      r_d_hold  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdy     <= 1'b0;
      d_rdy     <= 1'b0;
      conf_cnt  <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      i_rdy  <= 1'b0;
      d_rdy  <= 1'b0;

      if (w_conf && (conf_cnt != CONF_CNT_MAX))
        conf_cnt <= conf_cnt + 32'd1;

      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (r_state == S_DONE) begin
            if (r_grant == G_INST)
              r_i_hold <= mem_rdata;
            else if (!r_we)
              r_d_hold <= mem_rdata;
          end
          if (w_take) begin
            r_grant  <= w_pick;
            r_we     <= (w_pick == G_DATA) && d_we;
            mem_en   <= 1'b1;
            mem_we   <= (w_pick == G_DATA) && d_we;
            mem_addr <= w_addr_sel;
            if (w_pick == G_DATA)
              mem_wdata <= d_wdata;
            r_state  <= S_ACCESS;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_ACCESS: begin
          i_rdy   <= (r_grant == G_INST);
          d_rdy   <= (r_grant == G_DATA);
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
